pipelined_cla_addsub: RTL
=========================

// Module: pipelined_cla_addsub
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.
//  Splits WIDTH into STAGES equal segments, one per pipeline stage; each segment is built from
//  4-bit CLA groups with group-level lookahead, and the carry ripples stage to stage via registers.
//  Valid/ready handshake on both sides; produces result, carry-out, signed overflow and zero flags.
// PARAMETERS
//  WIDTH   32  operand/result width; WIDTH % (4*STAGES) == 0, else elaboration error
//  STAGES  4   pipeline stages = latency in cycles; 1 <= STAGES <= WIDTH/4
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      block can accept this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  op         in   2      [0]=0 add, [0]=1 sub (A-B); [1]=saturate (see CONFIGURATION)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  sum/difference
//  cout       out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      signed overflow
//  zero       out  1      result == 0
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all stage valid bits, out_valid, result, cout, ovf, zero -> 0;
//    in_ready -> 1 the cycle after reset deasserts. Reset mid-operation discards all in-flight ops.
//  - Accept when in_valid && in_ready. Sub: B' = ~b, carry-in = 1; add: B' = b, carry-in = 0.
//  - Stage k (0..STAGES-1) adds segment k of A/B' with registered carry from stage k-1;
//    upper segments travel skewed in stage registers, completed lower segments travel deskewed.
//  - Latency: exactly STAGES cycles from accept to out_valid with no backpressure; throughput 1/cycle.
//  - Stall: stall = out_valid && !out_ready. in_ready = !stall. On stall every stage register holds;
//    result/cout/ovf/zero stay stable while out_valid && !out_ready.
//  - Simultaneous out handshake and in accept in same cycle is legal; no bubble inserted.
//  - Bubbles (in_valid=0) propagate as invalid stages; they are not collapsed.
//  - ovf = (a[MSB] == B'[MSB]) && (result[MSB] != a[MSB]), computed in final stage, pre-saturation.
//  - zero evaluated on the final (post-saturation) result.
//  - Wrap-around: without saturation result is modulo 2^WIDTH; cout reflects the dropped bit.
//  - op captured at accept and carried with the operation; changes on op while stalled are ignored.
// CONFIGURATION
//  ADDSUB_SAT_EN defined: op[1]=1 selects signed saturation; on ovf result clamps to
//   2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative); ovf still reports 1; cout unchanged.
//  ADDSUB_SAT_EN undefined: op[1] ignored, no clamp logic synthesised; result always modulo.
// TESTING  (WIDTH=32, STAGES=4)
//  1 Reset: rst_n=0 two cycles -> out_valid=0, result=0, in_ready=1 after release.
//  2 Add 0x0000_FFFF+0x0000_0001 (cross-segment carry) -> 4 cycles later result=0x0001_0000, cout=0, zero=0.
//  3 Sub 0x0000_0005-0x0000_0005 -> result=0, zero=1, cout=1; sub 0-1 -> 0xFFFF_FFFF, cout=0.
//  4 Overflow 0x7FFF_FFFF+1 op=00 -> 0x8000_0000, ovf=1; op=10 with ADDSUB_SAT_EN -> 0x7FFF_FFFF, ovf=1.
//  5 Back-to-back 8 ops, out_ready low cycles 5-7 -> in_ready=0 during stall, outputs held, all 8 in order.
//  6 rst_n=0 with 3 ops in flight -> none emerge; next op after reset has latency 4.

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_cla_addsub
//   Pipelined carry-lookahead adder/subtractor for the ALU datapath.
//   WIDTH is split into STAGES equal segments, and each pipeline stage adds
//   one segment.
//   - Each segment is built from 4-bit CLA groups with group-level lookahead.
//   - The carry crosses from one stage to the next through a register.
//   - Upper operand bits travel forward in the stage registers, not yet
//     added (skewed).
//   - Completed low sum bits accumulate alongside them (deskewed).
//   Latency is STAGES cycles, throughput is one operation per cycle, and a
//   stalled output freezes the whole pipe.
//
// Optional feature macro: ADDSUB_SAT_EN
//   When defined, op[1]=1 clamps a signed overflow to the most positive or
//   most negative value. When undefined, op[1] is ignored and no clamp logic
//   exists.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands/op valid
//   in_ready   block can accept this cycle (low only while output is stalled)
//   a, b       operands, WIDTH bits
//   op         [0]=0 add, [0]=1 subtract (a-b); [1]=saturate (with ADDSUB_SAT_EN)
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     sum/difference, WIDTH bits
//   cout       carry out of MSB (subtract: 1 = no borrow)
//   ovf        signed overflow (before saturation)
//   zero       final result == 0
// ---------------------------------------------------------------------------
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG    = WIDTH / STAGES;
    localparam int GROUPS = SEG / 4;
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    generate
        if ((STAGES < 1) || (WIDTH % (4 * STAGES) != 0)) begin : g_bad_params
            $error("pipelined_cla_addsub: WIDTH must be a multiple of 4*STAGES and STAGES >= 1");
        end
    endgenerate

    // One segment of CLA: 4-bit groups with internal lookahead. Each group
    // forms its own generate/propagate pair, so the group carry chain only
    // takes one step per 4 bits.
    function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           cin);
        logic [SEG-1:0]  s;
        logic [GROUPS:0] gc;
        logic [3:0]      g, p, c;
        logic            gg, gp;
        s     = '0;
        gc    = '0;
        gc[0] = cin;
        for (int j = 0; j < GROUPS; j++) begin
            g    = x[4*j +: 4] & y[4*j +: 4];
            p    = x[4*j +: 4] ^ y[4*j +: 4];
            c[0] = gc[j];
            c[1] = g[0] | (p[0] & gc[j]);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & gc[j]);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & gc[j]);
            gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
            gp   = &p;
            gc[j+1]       = gg | (gp & gc[j]);
            s[4*j +: 4]   = p ^ c;
        end
        return {gc[GROUPS], s};
    endfunction

    logic stall;

    // Stage inputs (_st) and stage registers (_reg). Register k feeds stage k+1;
    // the last stage feeds the output registers directly.
    logic [WIDTH-1:0] a_st   [STAGES];
    logic [WIDTH-1:0] b_st   [STAGES];
    logic [WIDTH-1:0] s_st   [STAGES];
    logic             c_st   [STAGES];
    logic             v_st   [STAGES];
    logic [WIDTH-1:0] s_next [STAGES];
    logic             c_next [STAGES];

    logic [WIDTH-1:0] a_reg  [STAGES];
    logic [WIDTH-1:0] b_reg  [STAGES];
    logic [WIDTH-1:0] s_reg  [STAGES];
    logic             c_reg  [STAGES];
    logic             v_reg  [STAGES];

`ifdef ADDSUB_SAT_EN
    logic             sat_st  [STAGES];
    logic             sat_reg [STAGES];
`else
    logic             unused_sat;
    assign unused_sat = op[1];
`endif

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [SEG:0]     seg_sum;
            logic [WIDTH-1:0] seg_ext;

            if (gi == 0) begin : g_head
                // Subtraction is a + ~b + 1.
                assign a_st[gi] = a;
                assign b_st[gi] = op[0] ? ~b : b;
                assign s_st[gi] = '0;
                assign c_st[gi] = op[0];
                assign v_st[gi] = in_valid;
`ifdef ADDSUB_SAT_EN
                assign sat_st[gi] = op[1];
`endif
            end else begin : g_body
                assign a_st[gi] = a_reg[gi-1];
                assign b_st[gi] = b_reg[gi-1];
                assign s_st[gi] = s_reg[gi-1];
                assign c_st[gi] = c_reg[gi-1];
                assign v_st[gi] = v_reg[gi-1];
`ifdef ADDSUB_SAT_EN
                assign sat_st[gi] = sat_reg[gi-1];
`endif
            end

            assign seg_sum     = cla_seg(a_st[gi][gi*SEG +: SEG], b_st[gi][gi*SEG +: SEG], c_st[gi]);
            assign seg_ext     = WIDTH'(seg_sum[SEG-1:0]);
            // Bits above the completed segments are still zero, so OR merges in this segment.
            assign s_next[gi]  = s_st[gi] | (seg_ext << (gi * SEG));
            assign c_next[gi]  = seg_sum[SEG];
        end
    endgenerate

    // Final-stage flags. Overflow uses the effective operand B' (inverted for subtract).
    logic [WIDTH-1:0] sum_pre;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    assign sum_pre  = s_next[LAST];
    assign ovf_next = (a_st[LAST][MSB] == b_st[LAST][MSB]) && (sum_pre[MSB] != a_st[LAST][MSB]);

`ifdef ADDSUB_SAT_EN
    logic [WIDTH-1:0] sat_val;
    // Overflow direction follows the sign of a: positive a can only overflow upward.
    assign sat_val  = a_st[LAST][MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign res_next = (sat_st[LAST] && ovf_next) ? sat_val : sum_pre;
`else
    assign res_next = sum_pre;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_reg[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_reg[k] <= a_st[k];
                b_reg[k] <= b_st[k];
                s_reg[k] <= s_next[k];
                c_reg[k] <= c_next[k];
                v_reg[k] <= v_st[k];
`ifdef ADDSUB_SAT_EN
                sat_reg[k] <= sat_st[k];
`endif
            end
            out_valid <= v_st[LAST];
            result    <= res_next;
            cout      <= c_next[LAST];
            ovf       <= ovf_next;
            zero      <= (res_next == '0);
        end
    end

endmodule
